event_filter_pipe: RTL
======================

Name: event_filter_pipe

Overview:
- Parametrised successor to the single-register DVS event filter.
- Accepts address-event tuples (x, y, t, p) over a valid/ready handshake and applies three filters: polarity mode, rectangular region of interest, and a global refractory time gap.
- Passing events are buffered in a small FIFO toward the downstream event consumer.
- Keeps saturating pass/drop statistics for host readout.

Parameters:
- XW, 8, x address width
- YW, 8, y address width
- TW, 8, timestamp width
- DEPTH, 4, output FIFO depth; power of two, ≥2
- CNTW, 16, statistics counter width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input event valid
- in_ready  out  1  input can accept
- x  in  XW  event x
- y  in  YW  event y
- t  in  TW  event timestamp
- p  in  1  event polarity
- cfg_pol_mode  in  2  00 pass all, 01 p=1 only, 10 p=0 only, 11 drop all
- roi_en  in  1  enable ROI filter
- roi_x_min  in  XW  ROI bound, inclusive
- roi_x_max  in  XW  ROI bound, inclusive
- roi_y_min  in  YW  ROI bound, inclusive
- roi_y_max  in  YW  ROI bound, inclusive
- refr  in  TW  minimum t gap between passed events; 0 disables
- cnt_clr  in  1  synchronous clear of statistics counters
- out_valid  out  1  output event valid
- out_ready  in  1  downstream accepts
- x_out  out  XW  output x
- y_out  out  YW  output y
- t_out  out  TW  output t
- p_out  out  1  output polarity
- pass_cnt  out  CNTW  events passed
- drop_cnt  out  CNTW  events dropped

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied.
  - out_valid=0; x_out/y_out/t_out/p_out=0.
  - pass_cnt=drop_cnt=0.
  - t_last=0, have_last=0.
  - in_ready=1 on the first cycle after reset release.
- Accept: handshake when in_valid & in_ready. in_ready = (fifo_count < DEPTH), registered state only; no combinational path from out_ready to in_ready.
- Filter decision is combinational on the accepted tuple and the config values in the same cycle. pass = pol_ok & roi_ok & refr_ok, where:
  - pol_ok follows cfg_pol_mode.
  - roi_ok = !roi_en | (x_min≤x≤x_max & y_min≤y≤y_max), unsigned compare. min>max means nothing passes while roi_en=1.
  - refr_ok = (refr==0) | !have_last | ((t − t_last) mod 2^TW ≥ refr). Timestamp wrap is handled by modular subtraction.
- Pass:
  - Tuple written to FIFO tail.
  - t_last←t, have_last←1.
  - pass_cnt++.
- Drop:
  - Handshake still completes; nothing written to FIFO.
  - t_last unchanged; drop_cnt++.
- Counters saturate at all-ones. cnt_clr zeroes both counters and wins over a same-cycle increment.
- Output: out_valid = FIFO non-empty. x_out/y_out/t_out/p_out present the FIFO head when out_valid=1 and are forced to 0 when out_valid=0. Pop on out_valid & out_ready.
- Latency: accepted passing event into an empty FIFO appears on out_valid on the next rising edge (1 cycle).
- Hold: head data is stable while out_valid=1 & out_ready=0.
- Simultaneous push and pop:
  - Count is unchanged.
  - If the FIFO is full, in_ready is already 0, so no push occurs; in_ready rises the cycle after the pop.
  - If the FIFO holds 1 entry, the head advances to the new entry the next cycle.
- Ordering: strict FIFO; pointers wrap modulo DEPTH.
- Config changes take effect on the next accepted event; already buffered events are unaffected.
- Reset mid-operation: buffered events are discarded and have_last is cleared.

Test Plan:
- Reset then 4 events (p=1,0,1,0), mode 01, roi_en=0, refr=0, out_ready=1 → only events 1 and 3 appear, each 1 cycle after acceptance; pass_cnt=2, drop_cnt=2.
- ROI x 10..20, y 5..5, roi_en=1; events (10,5), (21,5), (20,4), (20,5) → outputs (10,5) and (20,5) only; then min>max → all dropped.
- refr=10, events t=250, 252, 4 (wrapped, delta 10), 5 → pass 250, drop 252, pass 4, drop 5.
- out_ready=0, stream passing events → exactly DEPTH accepted, in_ready=0. Then out_ready=1 for one cycle → head popped, in_ready=1 next cycle, order preserved.
- Drive 2^CNTW+3 dropped events (CNTW overridden to 4) → drop_cnt holds 15. cnt_clr with a same-cycle drop → 0.
- Fill FIFO to 3, assert rst_n=0 asynchronously mid-cycle → out_valid and data go to 0 immediately. After release, the first event passes regardless of refr.

Source files
------------

// File: rtl/event_filter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : event_filter_pipe
// Brief    : Address-event filter (polarity, ROI, refractory gap) feeding a
//            small output FIFO, with saturating pass/drop statistics.
// Revision : 1.0 - initial release
// ============================================================================
module event_filter_pipe #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int TW    = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    input  logic [TW-1:0]   t,
    input  logic            p,
    input  logic [1:0]      cfg_pol_mode,
    input  logic            roi_en,
    input  logic [XW-1:0]   roi_x_min,
    input  logic [XW-1:0]   roi_x_max,
    input  logic [YW-1:0]   roi_y_min,
    input  logic [YW-1:0]   roi_y_max,
    input  logic [TW-1:0]   refr,
    input  logic            cnt_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XW-1:0]   x_out,
    output logic [YW-1:0]   y_out,
    output logic [TW-1:0]   t_out,
    output logic            p_out,
    output logic [CNTW-1:0] pass_cnt,
    output logic [CNTW-1:0] drop_cnt
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            EW      = XW + YW + TW + 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   t_last_q, t_last_d;
    logic            have_last_q, have_last_d;
    logic [CNTW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic            pol_ok;
    logic            roi_ok;
    logic            refr_ok;
    logic            pass_evt;
    logic [TW-1:0]   t_delta;
    logic [EW-1:0]   head;

    // in_ready depends on registered occupancy only, never on out_ready
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        pol_ok = 1'b0;
        case (cfg_pol_mode)
            2'b00:   pol_ok = 1'b1;
            2'b01:   pol_ok = p;
            2'b10:   pol_ok = ~p;
            default: pol_ok = 1'b0;
        endcase

        roi_ok = ~roi_en |
                 ((x >= roi_x_min) & (x <= roi_x_max) &
                  (y >= roi_y_min) & (y <= roi_y_max));

        // Modular subtraction absorbs timestamp wrap
        t_delta  = t - t_last_q;
        refr_ok  = (refr == '0) | ~have_last_q | (t_delta >= refr);
        pass_evt = pol_ok & roi_ok & refr_ok;
        push     = accept & pass_evt;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        t_last_d    = t_last_q;
        have_last_d = have_last_q;
        pass_cnt_d  = pass_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + AW'(1);
            t_last_d    = t;
            have_last_d = 1'b1;
            if (pass_cnt_q != CNT_MAX) begin
                pass_cnt_d = pass_cnt_q + CNTW'(1);
            end
        end
        if (accept && !pass_evt && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (cnt_clr) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            t_last_q    <= '0;
            have_last_q <= 1'b0;
            pass_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            t_last_q    <= t_last_d;
            have_last_q <= have_last_d;
            pass_cnt_q  <= pass_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {x, y, t, p};
        end
    end

    assign x_out    = out_valid ? head[EW-1 -: XW]      : '0;
    assign y_out    = out_valid ? head[TW+YW : TW+1]    : '0;
    assign t_out    = out_valid ? head[TW : 1]          : '0;
    assign p_out    = out_valid ? head[0]               : 1'b0;
    assign pass_cnt = pass_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
